// File: rtl/cu_pkg.sv
// Shared constants for the Mini-SRC control unit: instruction opcodes, ALU operation codes
// and sequencer state encodings.
package cu_pkg;

  localparam logic [4:0] OpLd   = 5'd0;
  localparam logic [4:0] OpLdi  = 5'd1;
  localparam logic [4:0] OpSt   = 5'd2;
  localparam logic [4:0] OpAdd  = 5'd3;
  localparam logic [4:0] OpSub  = 5'd4;
  localparam logic [4:0] OpAnd  = 5'd5;
  localparam logic [4:0] OpOr   = 5'd6;
  localparam logic [4:0] OpShr  = 5'd7;
  localparam logic [4:0] OpShra = 5'd8;
  localparam logic [4:0] OpShl  = 5'd9;
  localparam logic [4:0] OpRor  = 5'd10;
  localparam logic [4:0] OpRol  = 5'd11;
  localparam logic [4:0] OpAddi = 5'd12;
  localparam logic [4:0] OpAndi = 5'd13;
  localparam logic [4:0] OpOri  = 5'd14;
  localparam logic [4:0] OpMul  = 5'd15;
  localparam logic [4:0] OpDiv  = 5'd16;
  localparam logic [4:0] OpNeg  = 5'd17;
  localparam logic [4:0] OpNot  = 5'd18;
  localparam logic [4:0] OpBr   = 5'd19;
  localparam logic [4:0] OpJr   = 5'd20;
  localparam logic [4:0] OpJal  = 5'd21;
  localparam logic [4:0] OpIn   = 5'd22;
  localparam logic [4:0] OpOut  = 5'd23;
  localparam logic [4:0] OpMfhi = 5'd24;
  localparam logic [4:0] OpMflo = 5'd25;
  localparam logic [4:0] OpNop  = 5'd26;
  localparam logic [4:0] OpHalt = 5'd27;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluAnd  = 4'd2;
  localparam logic [3:0] AluOr   = 4'd3;
  localparam logic [3:0] AluShr  = 4'd4;
  localparam logic [3:0] AluShra = 4'd5;
  localparam logic [3:0] AluShl  = 4'd6;
  localparam logic [3:0] AluRor  = 4'd7;
  localparam logic [3:0] AluRol  = 4'd8;
  localparam logic [3:0] AluMul  = 4'd9;
  localparam logic [3:0] AluDiv  = 4'd10;
  localparam logic [3:0] AluNeg  = 4'd11;
  localparam logic [3:0] AluNot  = 4'd12;

  localparam logic [1:0] StReset = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StHalt  = 2'd2;
  localparam logic [1:0] StPause = 2'd3;

endpackage

// File: rtl/cu_alu_decode.sv
// Combinational opcode to ALU operation mapping; address arithmetic (ld/ldi/st/br) uses ADD.
module cu_alu_decode
  import cu_pkg::*;
(
  input  logic [4:0] in_opcode,
  output logic [3:0] out_alu_code
);

  always_comb begin
    out_alu_code = AluAdd;
    case (in_opcode)
      OpSub:         out_alu_code = AluSub;
      OpAnd, OpAndi: out_alu_code = AluAnd;
      OpOr, OpOri:   out_alu_code = AluOr;
      OpShr:         out_alu_code = AluShr;
      OpShra:        out_alu_code = AluShra;
      OpShl:         out_alu_code = AluShl;
      OpRor:         out_alu_code = AluRor;
      OpRol:         out_alu_code = AluRol;
      OpMul:         out_alu_code = AluMul;
      OpDiv:         out_alu_code = AluDiv;
      OpNeg:         out_alu_code = AluNeg;
      OpNot:         out_alu_code = AluNot;
      default:       out_alu_code = AluAdd;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini-SRC control sequencer: fetch T0-T2, opcode-dependent execute T3-T7.
// Optional single-step mode (PAUSE state, in_step_go input) under CU_SINGLE_STEP_EN.
module control_unit
  import cu_pkg::*;
#(
  parameter int unsigned LAST_STEP = 7
) (
  input  logic        clk,
  input  logic        in_reset,
  input  logic [31:0] in_ir,
  input  logic        in_branch,
`ifdef CU_SINGLE_STEP_EN
  input  logic        in_step_go,
`endif
  output logic [3:0]  out_alu_opcode,
  output logic        out_reg_clear, out_mdr_select, out_inc_pc,
  output logic        out_gra, out_grb, out_grc, out_ba_read,
  output logic        out_regfile_read, out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read,
  output logic        out_pc_read, out_mdr_read, out_inport_read, out_c_read, out_mem_read,
  output logic        out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write,
  output logic        out_mdr_write, out_ir_write, out_y_write, out_mar_write, out_mem_write,
  output logic        out_outport_write, out_con_write,
  output logic [2:0]  out_step,
  output logic        out_halted,
  output logic        out_illegal
);

  localparam logic [2:0] LastStep = 3'(LAST_STEP);

  logic [1:0] state_q, state_d;
  logic [2:0] step_q, step_d;
  logic       illegal_q, illegal_d;
  logic [4:0] opcode;
  logic [3:0] alu_code;
  logic       last_step, stop_ok, stop_bad;
  logic       unused_ir;

  assign opcode    = in_ir[31:27];
  assign unused_ir = ^in_ir[26:0];
  assign out_step  = step_q;

  cu_alu_decode u_alu_decode (
    .in_opcode   (opcode),
    .out_alu_code(alu_code)
  );

  always_comb begin
    out_alu_opcode = AluAdd;
    {out_reg_clear, out_mdr_select, out_inc_pc, out_gra, out_grb, out_grc, out_ba_read} = '0;
    {out_regfile_read, out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read, out_pc_read,
     out_mdr_read, out_inport_read, out_c_read, out_mem_read} = '0;
    {out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write, out_mdr_write,
     out_ir_write, out_y_write, out_mar_write, out_mem_write, out_outport_write,
     out_con_write} = '0;
    out_halted  = 1'b0;
    out_illegal = 1'b0;
    last_step   = 1'b0;
    stop_ok     = 1'b0;
    stop_bad    = 1'b0;
    case (state_q)
      StReset: out_reg_clear = 1'b1;
      StHalt: begin
        out_halted  = 1'b1;
        out_illegal = illegal_q;
      end
      StPause: ;
      StRun: begin
        case (step_q)
          3'd0: {out_pc_read, out_mar_write, out_inc_pc, out_pc_write, out_mem_read} = '1;
          3'd1: {out_mdr_select, out_mdr_write} = '1;
          3'd2: begin
            {out_mdr_read, out_ir_write} = '1;
            last_step = (opcode == OpNop);
          end
          default: begin
            case (opcode)
              OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShra, OpShl, OpRor, OpRol,
              OpAddi, OpAndi, OpOri: begin
                case (step_q)
                  3'd3: {out_grb, out_regfile_read, out_y_write} = '1;
                  3'd4: begin
                    if (opcode inside {OpAddi, OpAndi, OpOri}) out_c_read = 1'b1;
                    else {out_grc, out_regfile_read} = '1;
                    out_alu_opcode = alu_code;
                    out_z_write    = 1'b1;
                  end
                  default: begin
                    {out_z_lo_read, out_gra, out_regfile_write} = '1;
                    last_step = 1'b1;
                  end
                endcase
              end
              OpLdi, OpLd, OpSt: begin
                case (step_q)
                  3'd3: {out_grb, out_ba_read, out_y_write} = '1;
                  3'd4: begin
                    out_c_read     = 1'b1;
                    out_alu_opcode = alu_code;
                    out_z_write    = 1'b1;
                  end
                  3'd5: begin
                    out_z_lo_read = 1'b1;
                    if (opcode == OpLdi) begin
                      {out_gra, out_regfile_write} = '1;
                      last_step = 1'b1;
                    end else begin
                      out_mar_write = 1'b1;
                      out_mem_read  = (opcode == OpLd);
                    end
                  end
                  3'd6: begin
                    // st drives Ra onto the bus, so MDR takes the bus path here
                    if (opcode == OpLd) {out_mem_read, out_mdr_select, out_mdr_write} = '1;
                    else {out_gra, out_regfile_read, out_mdr_write} = '1;
                  end
                  default: begin
                    if (opcode == OpLd) {out_mdr_read, out_gra, out_regfile_write} = '1;
                    else out_mem_write = 1'b1;
                    last_step = 1'b1;
                  end
                endcase
              end
              OpMul, OpDiv: begin
                case (step_q)
                  3'd3: {out_gra, out_regfile_read, out_y_write} = '1;
                  3'd4: begin
                    {out_grb, out_regfile_read, out_z_write} = '1;
                    out_alu_opcode = alu_code;
                  end
                  3'd5: {out_z_lo_read, out_lo_write} = '1;
                  default: begin
                    {out_z_hi_read, out_hi_write} = '1;
                    last_step = 1'b1;
                  end
                endcase
              end
              OpNeg, OpNot: begin
                if (step_q == 3'd3) begin
                  {out_grb, out_regfile_read, out_z_write} = '1;
                  out_alu_opcode = alu_code;
                end else begin
                  {out_z_lo_read, out_gra, out_regfile_write} = '1;
                  last_step = 1'b1;
                end
              end
              OpBr: begin
                case (step_q)
                  3'd3: {out_gra, out_regfile_read, out_con_write} = '1;
                  3'd4: {out_pc_read, out_y_write} = '1;
                  3'd5: begin
                    {out_c_read, out_z_write} = '1;
                    out_alu_opcode = alu_code;
                  end
                  default: begin
                    out_z_lo_read = 1'b1;
                    out_pc_write  = in_branch;
                    last_step     = 1'b1;
                  end
                endcase
              end
              OpJr: begin
                {out_gra, out_regfile_read, out_pc_write} = '1;
                last_step = 1'b1;
              end
              OpIn: begin
                {out_inport_read, out_gra, out_regfile_write} = '1;
                last_step = 1'b1;
              end
              OpOut: begin
                {out_gra, out_regfile_read, out_outport_write} = '1;
                last_step = 1'b1;
              end
              OpMfhi: begin
                {out_hi_read, out_gra, out_regfile_write} = '1;
                last_step = 1'b1;
              end
              OpMflo: begin
                {out_lo_read, out_gra, out_regfile_write} = '1;
                last_step = 1'b1;
              end
              OpHalt:  stop_ok = 1'b1;
              OpJal:   stop_bad = 1'b1;
              default: stop_bad = 1'b1;
            endcase
          end
        endcase
      end
      default: out_reg_clear = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    illegal_d = illegal_q;
    case (state_q)
      StReset: begin
        state_d   = StRun;
        step_d    = '0;
        illegal_d = 1'b0;
      end
      StRun: begin
        if (stop_ok || stop_bad) begin
          state_d   = StHalt;
          step_d    = '0;
          illegal_d = stop_bad;
        end else if (last_step || step_q == LastStep) begin
          step_d = '0;
`ifdef CU_SINGLE_STEP_EN
          state_d = StPause;
`endif
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      StPause: begin
`ifdef CU_SINGLE_STEP_EN
        if (in_step_go) begin
          state_d = StRun;
          step_d  = '0;
        end
`else
        state_d = StRun;
        step_d  = '0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge in_reset) begin
    if (in_reset) begin
      state_q   <= StReset;
      step_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
